// File: rtl/alu_pkg.sv
// Shared types and encodings for the ALU issue controller and its decoder.
package alu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned OP_W   = 4;

  typedef enum logic [OP_W-1:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SUB  = 4'b0110,
    ALU_ANDI = 4'b1000,
    ALU_ORI  = 4'b1001,
    ALU_ADDI = 4'b1010
  } alu_op_e;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE = 7'b0010011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_OR  = 3'b110;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXEC,
    ST_WB
  } issue_state_e;

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of the supported RV32I ALU subset.
module alu_decode
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  output alu_op_e         alu_op,
  output logic            is_legal,
  output logic            uses_imm
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       unused_fields;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];
  // register and immediate fields carry no opcode information
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  // opcode/funct lookup; anything not listed stays illegal
  always_comb begin
    alu_op   = ALU_AND;
    is_legal = 1'b0;
    uses_imm = 1'b0;
    if (opc == OPC_RTYPE) begin
      if (f7 == F7_BASE) begin
        case (f3)
          F3_ADD: begin alu_op = ALU_ADD; is_legal = 1'b1; end
          F3_AND: begin alu_op = ALU_AND; is_legal = 1'b1; end
          F3_OR:  begin alu_op = ALU_OR;  is_legal = 1'b1; end
          default: ;
        endcase
      end else if (f7 == F7_SUB && f3 == F3_ADD) begin
        alu_op   = ALU_SUB;
        is_legal = 1'b1;
      end
    end else if (opc == OPC_ITYPE) begin
      uses_imm = 1'b1;
      case (f3)
        F3_ADD: begin alu_op = ALU_ADDI; is_legal = 1'b1; end
        F3_AND: begin alu_op = ALU_ANDI; is_legal = 1'b1; end
        F3_OR:  begin alu_op = ALU_ORI;  is_legal = 1'b1; end
        default: uses_imm = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Four-state issue controller: accept, decode/read operands, execute, write back.
// Optional performance counters are enabled with `define ALU_ISSUE_PERF_EN.
module alu_issue_ctrl
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [XLEN-1:0]   instr,
  output logic              instr_ready,
  output logic [REG_AW-1:0] rs1_addr,
  output logic [REG_AW-1:0] rs2_addr,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  output logic [XLEN-1:0]   data1,
  output logic [XLEN-1:0]   data2,
  output logic [XLEN-1:0]   imm,
  output logic [OP_W-1:0]   ALU_control,
  input  logic [XLEN-1:0]   ALU_result,
  output logic              rd_we,
  output logic [REG_AW-1:0] rd_addr,
  output logic [XLEN-1:0]   rd_wdata,
  output logic              illegal_instr,
  output logic              busy
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]       retired_cnt,
  output logic [31:0]       illegal_cnt
`endif
);

  issue_state_e    state, state_d;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] dec_instr;
  alu_op_e         dec_op;
  logic            dec_legal;
  logic            unused_dec_uses_imm;
  logic            hs;

  assign hs = instr_valid & instr_ready;

  // read addresses come straight from the captured word's flops
  assign rs1_addr = instr_q[19:15];
  assign rs2_addr = instr_q[24:20];

  // decode the offered word while idle (for the illegal pulse), the captured word otherwise
  assign dec_instr = (state == ST_IDLE) ? instr : instr_q;

  alu_decode u_decode (
    .instr    (dec_instr),
    .alu_op   (dec_op),
    .is_legal (dec_legal),
    .uses_imm (unused_dec_uses_imm)
  );

  // next-state logic
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:   if (hs) state_d = ST_DECODE;
      ST_DECODE: state_d = dec_legal ? ST_EXEC : ST_IDLE;
      ST_EXEC:   state_d = ST_WB;
      ST_WB:     state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // state register and registered datapath/handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      instr_q       <= '0;
      instr_ready   <= 1'b1;
      busy          <= 1'b0;
      illegal_instr <= 1'b0;
      rd_we         <= 1'b0;
      rd_addr       <= '0;
      rd_wdata      <= '0;
      data1         <= '0;
      data2         <= '0;
      imm           <= '0;
      ALU_control   <= 4'b0000;
    end else begin
      state         <= state_d;
      instr_ready   <= (state_d == ST_IDLE);
      busy          <= (state_d != ST_IDLE);
      illegal_instr <= hs & ~dec_legal;
      rd_we         <= 1'b0;
      if (hs) instr_q <= instr;
      if (state == ST_DECODE && dec_legal) begin
        data1       <= rs1_data;
        data2       <= rs2_data;
        ALU_control <= dec_op;
        imm         <= {{20{instr_q[31]}}, instr_q[31:20]};
      end
      if (state == ST_EXEC) rd_wdata <= ALU_result;
      // x0 writes are dropped but the slot still retires
      if (state == ST_WB) begin
        rd_we   <= (instr_q[11:7] != 5'd0);
        rd_addr <= instr_q[11:7];
      end
    end
  end

`ifdef ALU_ISSUE_PERF_EN
  // retire and illegal-pulse counters, free-running modulo 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt <= '0;
      illegal_cnt <= '0;
    end else begin
      if (state == ST_WB) retired_cnt <= retired_cnt + 32'd1;
      if (illegal_instr)  illegal_cnt <= illegal_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed scenarios plus randomized instruction mix.
module tb_alu_issue_ctrl;

  logic        clk, rst_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] rs1_data, rs2_data, data1, data2, imm, ALU_result, rd_wdata;
  logic [3:0]  ALU_control;
  logic        rd_we, illegal_instr, busy;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] retired_cnt, illegal_cnt;
`endif

  logic [31:0] regs [32];
  int n_tests = 0;
  int n_fail  = 0;

  // model state
  logic [3:0]  last_op;
  logic [31:0] last_d1, last_d2, last_imm;
  int          exp_ret, exp_ill;

  alu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .data1(data1), .data2(data2),
    .imm(imm), .ALU_control(ALU_control), .ALU_result(ALU_result),
    .rd_we(rd_we), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
    .illegal_instr(illegal_instr), .busy(busy)
`ifdef ALU_ISSUE_PERF_EN
    , .retired_cnt(retired_cnt), .illegal_cnt(illegal_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // environment register file and ALU
  assign rs1_data = regs[rs1_addr];
  assign rs2_data = regs[rs2_addr];
  always_comb begin
    case (ALU_control)
      4'b0010: ALU_result = data1 + data2;
      4'b0110: ALU_result = data1 - data2;
      4'b0000: ALU_result = data1 & data2;
      4'b0001: ALU_result = data1 | data2;
      4'b1010: ALU_result = data1 + imm;
      4'b1000: ALU_result = data1 & imm;
      4'b1001: ALU_result = data1 | imm;
      default: ALU_result = 32'hDEAD_BEEF;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // architectural meaning of each supported mnemonic
  function automatic void predict(input logic [31:0] ins, input logic [31:0] a,
                                  input logic [31:0] b, output bit legal,
                                  output logic [3:0] op, output logic [31:0] res);
    logic [31:0] i;
    i = {{20{ins[31]}}, ins[31:20]};
    legal = 1'b1; op = 4'b0000; res = 32'd0;
    if      (ins[6:0] == 7'h33 && ins[31:25] == 7'h00 && ins[14:12] == 3'd0) begin op = 4'b0010; res = a + b; end
    else if (ins[6:0] == 7'h33 && ins[31:25] == 7'h20 && ins[14:12] == 3'd0) begin op = 4'b0110; res = a - b; end
    else if (ins[6:0] == 7'h33 && ins[31:25] == 7'h00 && ins[14:12] == 3'd7) begin op = 4'b0000; res = a & b; end
    else if (ins[6:0] == 7'h33 && ins[31:25] == 7'h00 && ins[14:12] == 3'd6) begin op = 4'b0001; res = a | b; end
    else if (ins[6:0] == 7'h13 && ins[14:12] == 3'd0) begin op = 4'b1010; res = a + i; end
    else if (ins[6:0] == 7'h13 && ins[14:12] == 3'd7) begin op = 4'b1000; res = a & i; end
    else if (ins[6:0] == 7'h13 && ins[14:12] == 3'd6) begin op = 4'b1001; res = a | i; end
    else legal = 1'b0;
  endfunction

  // offer one instruction (caller is just after a falling edge) and follow it to completion
  task automatic run_instr(input logic [31:0] ins);
    bit          legal;
    logic [3:0]  op;
    logic [31:0] res, a, b, im;
    logic [4:0]  rd;
    int          wait_n;
    a  = regs[ins[19:15]];
    b  = regs[ins[24:20]];
    im = {{20{ins[31]}}, ins[31:20]};
    rd = ins[11:7];
    predict(ins, a, b, legal, op, res);
    instr_valid = 1'b1;
    instr       = ins;
    wait_n      = 0;
    while (!instr_ready && wait_n < 10) begin
      @(negedge clk);
      wait_n++;
    end
    chk("accept", 32'(instr_ready), 32'd1);
    if (!instr_ready) begin
      instr_valid = 1'b0;
      return;
    end
    @(negedge clk);
    instr_valid = 1'b0;
    chk("dec_busy", 32'(busy), 32'd1);
    chk("dec_ready", 32'(instr_ready), 32'd0);
    chk("dec_illegal", 32'(illegal_instr), 32'(!legal));
    chk("dec_rs1", 32'(rs1_addr), 32'(ins[19:15]));
    chk("dec_rs2", 32'(rs2_addr), 32'(ins[24:20]));
    chk("dec_rdwe", 32'(rd_we), 32'd0);
    @(negedge clk);
    if (!legal) begin
      exp_ill++;
      chk("ill_busy", 32'(busy), 32'd0);
      chk("ill_ready", 32'(instr_ready), 32'd1);
      chk("ill_pulse_end", 32'(illegal_instr), 32'd0);
      chk("ill_op_hold", 32'(ALU_control), 32'(last_op));
      chk("ill_imm_hold", imm, last_imm);
      chk("ill_d1_hold", data1, last_d1);
      chk("ill_d2_hold", data2, last_d2);
      chk("ill_rdwe", 32'(rd_we), 32'd0);
      return;
    end
    chk("ex_op", 32'(ALU_control), 32'(op));
    chk("ex_d1", data1, a);
    chk("ex_d2", data2, b);
    chk("ex_imm", imm, im);
    chk("ex_busy", 32'(busy), 32'd1);
    chk("ex_rdwe", 32'(rd_we), 32'd0);
    last_op = op; last_d1 = a; last_d2 = b; last_imm = im;
    @(negedge clk);
    chk("wb_wdata", rd_wdata, res);
    chk("wb_rdwe", 32'(rd_we), 32'd0);
    @(negedge clk);
    chk("out_rdwe", 32'(rd_we), 32'(rd != 5'd0));
    chk("out_busy", 32'(busy), 32'd0);
    chk("out_ready", 32'(instr_ready), 32'd1);
    chk("out_wdata", rd_wdata, res);
    if (rd != 5'd0) begin
      chk("out_rdaddr", 32'(rd_addr), 32'(rd));
      regs[rd] = res;
    end
    exp_ret++;
  endtask

  task automatic model_reset();
    last_op = 4'b0000; last_d1 = '0; last_d2 = '0; last_imm = '0;
    exp_ret = 0; exp_ill = 0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rd, r1, r2;
    logic [11:0] i12;
    logic [2:0]  f3;
    rd  = 5'($urandom); r1 = 5'($urandom); r2 = 5'($urandom);
    i12 = 12'($urandom); f3 = 3'($urandom);
    case ($urandom_range(0, 9))
      0: return {7'h00, r2, r1, 3'd0, rd, 7'h33};
      1: return {7'h20, r2, r1, 3'd0, rd, 7'h33};
      2: return {7'h00, r2, r1, 3'd7, rd, 7'h33};
      3: return {7'h00, r2, r1, 3'd6, rd, 7'h33};
      4: return {i12, r1, 3'd0, rd, 7'h13};
      5: return {i12, r1, 3'd7, rd, 7'h13};
      6: return {i12, r1, 3'd6, rd, 7'h13};
      7: return {7'($urandom), r2, r1, f3, rd, 7'h33};
      8: return $urandom;
      default: return {i12, r1, f3, rd, 7'h13};
    endcase
  endfunction

  initial begin
    int acc_idx [$];
    int we_cnt;
    bit we_seen;
    regs[0] = 32'd0;
    for (int i = 1; i < 32; i++) regs[i] = $urandom;
    regs[1] = 32'd5;
    regs[2] = 32'd7;
    model_reset();
    rst_n = 1'b0; instr_valid = 1'b0; instr = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdwe", 32'(rd_we), 32'd0);
    chk("rst_op", 32'(ALU_control), 32'd0);
    chk("rst_wdata", rd_wdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // directed: add, sub, addi -1, xor (illegal), add x0
    run_instr(32'h002081B3);
    run_instr(32'h402081B3);
    run_instr(32'hFFF08193);
    @(negedge clk);
    run_instr(32'h0020C1B3);
    run_instr(32'h00208033);

    // instr_valid held through busy: one acceptance every 4 cycles
    @(negedge clk);
    instr_valid = 1'b1;
    instr = 32'h002082B3;
    we_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (instr_ready) acc_idx.push_back(i);
      if (rd_we) we_cnt++;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    if (rd_we) we_cnt++;
    chk("bp_accepts", 32'(acc_idx.size()), 32'd3);
    if (acc_idx.size() >= 2) chk("bp_gap", 32'(acc_idx[1] - acc_idx[0]), 32'd4);
    chk("bp_writes", 32'(we_cnt), 32'd3);
    regs[5] = regs[1] + regs[2];

    // reset in the middle of EXEC
    @(negedge clk);
    instr_valid = 1'b1;
    instr = 32'h002081B3;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_ready", 32'(instr_ready), 32'd1);
    chk("mrst_d1", data1, 32'd0);
    chk("mrst_d2", data2, 32'd0);
    chk("mrst_imm", imm, 32'd0);
    chk("mrst_op", 32'(ALU_control), 32'd0);
    chk("mrst_wdata", rd_wdata, 32'd0);
    chk("mrst_addrs", 32'({rs1_addr, rs2_addr, rd_addr}), 32'd0);
    chk("mrst_pulses", 32'({rd_we, illegal_instr}), 32'd0);
    model_reset();
    we_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rd_we) we_seen = 1'b1;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (rd_we) we_seen = 1'b1;
    end
    chk("mrst_no_wb", 32'(we_seen), 32'd0);

    // first handshake right on the first edge after release
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_instr(32'h002081B3);
    run_instr(32'h402081B3);
    run_instr(32'h0020C1B3);
    run_instr(32'hFFF08193);
`ifdef ALU_ISSUE_PERF_EN
    chk("perf_retired", retired_cnt, 32'd3);
    chk("perf_illegal", illegal_cnt, 32'd1);
`endif

    // randomized mix against the model
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      run_instr(rand_instr());
    end
`ifdef ALU_ISSUE_PERF_EN
    chk("perf_retired_end", retired_cnt, 32'(exp_ret));
    chk("perf_illegal_end", illegal_cnt, 32'(exp_ill));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; `rst_n` low resets all state immediately, independent of `clk`.
REQ-002 Ports (name, direction, width, meaning):
- `clk`, in, 1, rising-edge clock.
- `rst_n`, in, 1, async active-low reset.
- `instr_valid`, in, 1, instruction offered.
- `instr`, in, 32, RV32I instruction word.
- `instr_ready`, out, 1, block can accept an instruction.
- `rs1_addr`, `rs2_addr`, out, 5, register-file read addresses.
- `rs1_data`, `rs2_data`, in, 32, combinational register-file read data.
- `data1`, `data2`, out, 32, ALU operands.
- `imm`, out, 32, ALU immediate.
- `ALU_control`, out, 4, ALU operation code.
- `ALU_result`, in, 32, combinational ALU output.
- `rd_we`, out, 1, register-file write enable, one-cycle pulse.
- `rd_addr`, out, 5, write address.
- `rd_wdata`, out, 32, write data.
- `illegal_instr`, out, 1, one-cycle pulse on an undecodable instruction.
- `busy`, out, 1, FSM not in IDLE.

Function
REQ-003 FSM states: IDLE, DECODE, EXEC, WB. Transitions:
- IDLE goes to DECODE on handshake.
- DECODE goes to EXEC if legal, or to IDLE if illegal.
- EXEC goes to WB.
- WB goes to IDLE.
REQ-004 `instr_ready` = 1 only in IDLE. Handshake = `instr_valid` & `instr_ready` on a rising edge; `instr` is captured into an internal register.
REQ-005 `instr_valid` asserted outside IDLE SHALL be ignored. The source holds `instr` until accepted.
REQ-006 DECODE: `rs1_addr` = `instr[19:15]` and `rs2_addr` = `instr[24:20]`, both from the captured word. At the end of DECODE, `rs1_data`/`rs2_data` are registered into `data1`/`data2`, the decoded op into `ALU_control`, and sext(`instr[31:20]`) into `imm`.
REQ-007 Decode table (`ALU_control` code, opcode, funct3, funct7):
- ADD: `0010`, opcode `0110011`, funct3 `000`, funct7 `0000000`.
- SUB: `0110`, opcode `0110011`, funct3 `000`, funct7 `0100000`.
- AND: `0000`, opcode `0110011`, funct3 `111`, funct7 `0000000`.
- OR: `0001`, opcode `0110011`, funct3 `110`, funct7 `0000000`.
- ADDI: `1010`, opcode `0010011`, funct3 `000`.
- ANDI: `1000`, opcode `0010011`, funct3 `111`.
- ORI: `1001`, opcode `0010011`, funct3 `110`.
REQ-008 Every other encoding is illegal:
- `illegal_instr` pulses for exactly the DECODE cycle.
- There is no `rd_we` and no change to `data1`/`data2`/`imm`/`ALU_control`.
REQ-009 EXEC: `ALU_result` is sampled into `rd_wdata` at the end of EXEC.
REQ-010 WB: `rd_we` = 1 for exactly one cycle, with `rd_addr` = `instr[11:7]`. If `rd_addr` = 0, `rd_we` SHALL stay 0.
REQ-011 Latency: handshake on edge T gives `rd_we` high during the cycle after edge T+3. Throughput is one instruction per 4 cycles, and the next handshake is possible on edge T+4.
REQ-012 `data1`, `data2`, `imm`, `ALU_control`, `rd_addr` and `rd_wdata` SHALL hold their last values until next updated.
REQ-013 `busy` = (state != IDLE).

Reset
REQ-014 On `rst_n` low:
- State becomes IDLE.
- `instr_ready` = 1.
- `rd_we`, `illegal_instr` and `busy` = 0.
- `data1`, `data2`, `imm`, `rd_wdata` = 0.
- `ALU_control` = `4'b0000`.
- `rs1_addr`, `rs2_addr`, `rd_addr` = 0.
REQ-015 Reset mid-instruction SHALL abandon the instruction with no write-back. After release, the first handshake is possible on the first rising edge.

Configuration
REQ-016 Macro `ALU_ISSUE_PERF_EN`.
- When defined: adds outputs `retired_cnt` [31:0] and `illegal_cnt` [31:0], both reset to 0.
  - `retired_cnt` increments on each WB cycle, including writes suppressed because `rd` = x0.
  - `illegal_cnt` increments on each `illegal_instr` pulse.
  - Both wrap modulo 2^32.
- When undefined: the ports and counters are absent and behaviour is otherwise identical.

Structure
REQ-017 Package `alu_pkg` SHALL hold:
- the `alu_op_e` enum (4-bit codes per REQ-007);
- the `OPC_RTYPE`/`OPC_ITYPE` constants;
- the funct3/funct7 constants;
- the `issue_state_e` enum.
REQ-018 The decode table SHALL be one combinational sub-module, `alu_decode`: inputs are the instruction; outputs are `alu_op`, `is_legal`, `uses_imm`.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- ADD: x1=5, x2=7, `instr`=`0x002081B3` (add x3,x1,x2) -> `ALU_control`=`0010`, `rd_we` pulse at T+3 with `rd_addr`=3, `rd_wdata`=12.
- SUB: x1=5, x2=7, `instr`=`0x402081B3` -> `ALU_control`=`0110`, `rd_wdata`=`0xFFFFFFFE`.
- ADDI with negative immediate: `instr`=`0xFFF08193` (addi x3,x1,-1) -> `imm`=`0xFFFFFFFF`, `ALU_control`=`1010`.
- Illegal, x0 destination and back-pressure:
  - `instr`=`0x0020C1B3` (xor) -> `illegal_instr` pulse, no `rd_we`, back in IDLE after 2 cycles.
  - add x0 -> no `rd_we`.
  - `instr_valid` held through `busy` -> exactly one acceptance per 4 cycles.
- Reset mid-EXEC: `rst_n` low during EXEC -> outputs at REQ-014 values immediately, no `rd_we`.
- With `ALU_ISSUE_PERF_EN`: 3 legal + 1 illegal instruction -> `retired_cnt`=3, `illegal_cnt`=1.
